// File: rtl/frame_pkg.sv
// Shared framing constants and state type for the 9-bit frame protocol.
// Used by both the transmitter and the receiver so framing stays in step.
package frame_pkg;

  localparam int FRAME_W = 9;
  localparam int IDX_W   = 4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/frame_tx_if.sv
// Request/status bundle between control logic and the frame transmitter.
// The master requests frames; the slave reports line and progress state.
interface frame_tx_if;
  import frame_pkg::*;

  logic               send;
  logic [FRAME_W-1:0] frame_to_transmit;
  logic               tx;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   bit_idx;

  modport master (
    output send, frame_to_transmit,
    input  tx, busy, done, bit_idx
  );

  modport slave (
    input  send, frame_to_transmit,
    output tx, busy, done, bit_idx
  );

endinterface

// File: rtl/frame_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Shared with the receiver's sampling timer.
module bit_timer #(
  parameter  int CLKS_PER_BIT = 16,
  localparam int W = $clog2(CLKS_PER_BIT)
) (
  input  logic         clk,
  input  logic         clear,
  output logic [W-1:0] cnt,
  output logic         tick
);

  assign tick = (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/frame_tx.sv
// Serial transmitter for 9-bit frames: start, 9 data bits LSB-first, stop.
// Define FRAME_TX_PARITY_EN to insert an even-parity bit before stop.
module frame_tx
  import frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  frame_tx_if.slave  bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  tx_state_t          state, state_n;
  logic [FRAME_W-1:0] sh, sh_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [TW-1:0]      cnt;
  logic               tick;
  logic               clr;
  logic               tx_q, tx_n;
  logic               busy_q, busy_n;
  logic               done_q, done_n;
`ifdef FRAME_TX_PARITY_EN
  logic               par, par_n;
`endif

  // Timer is held at zero while idle so START begins on a fresh bit period.
  assign clr = rst | (state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk   (clk),
    .clear (clr),
    .cnt   (cnt),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
`ifdef FRAME_TX_PARITY_EN
    par_n   = par;
`endif
    unique case (state)
      IDLE: begin
        if (bus.send) begin
          state_n = START;
          sh_n    = bus.frame_to_transmit;
`ifdef FRAME_TX_PARITY_EN
          par_n   = ^bus.frame_to_transmit;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          sh_n = sh >> 1;
          if (idx == IDX_W'(FRAME_W - 1)) begin
            idx_n = '0;
`ifdef FRAME_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
`ifdef FRAME_TX_PARITY_EN
      PARITY: begin
        if (tick) state_n = STOP;
      end
`endif
      STOP: begin
        if (tick) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Line level follows the state being entered so tx is a pure flop.
    tx_n = LINE_IDLE;
    unique case (state_n)
      IDLE:    tx_n = LINE_IDLE;
      START:   tx_n = LINE_START;
      DATA:    tx_n = sh_n[0];
`ifdef FRAME_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      STOP:    tx_n = LINE_STOP;
      default: tx_n = LINE_IDLE;
    endcase

    busy_n = (state_n != IDLE);
    done_n = (state == STOP) && (cnt == TW'(CLKS_PER_BIT - 2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sh     <= '0;
      idx    <= '0;
      tx_q   <= LINE_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      idx    <= idx_n;
      tx_q   <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
`ifdef FRAME_TX_PARITY_EN
      par    <= par_n;
`endif
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bit_idx = idx;

endmodule
